// File: rtl/menu_ctrl_if.sv
// rtl/menu_ctrl_if.sv - menu controller buttons, frame strobe and display-facing outputs
interface menu_ctrl_if #(
  parameter int N_ITEMS = 4
);
  localparam int SEL_W = $clog2(N_ITEMS);

  logic                   newframe;
  logic                   btn_menu;
  logic                   btn_up;
  logic                   btn_down;
  logic                   btn_right;
  logic                   btn_left;
  logic                   menu_on;
  logic [SEL_W-1:0]       sel_item;
  logic [7:0]             exit_value;
  logic [8*N_ITEMS-1:0]   cfg_values;
  logic                   frame_upd;

  modport master (
    output newframe, btn_menu, btn_up, btn_down, btn_right, btn_left,
    input  menu_on, sel_item, exit_value, cfg_values, frame_upd
  );

  modport slave (
    input  newframe, btn_menu, btn_up, btn_down, btn_right, btn_left,
    output menu_on, sel_item, exit_value, cfg_values, frame_upd
  );
endinterface

// File: rtl/menu_ctrl.sv
// rtl/menu_ctrl.sv - debounced menu navigation FSM with frame-aligned value editing
// Optional auto-repeat of held navigation buttons: define MENU_AUTOREPEAT_EN.
module menu_ctrl #(
  parameter int         N_ITEMS        = 4,
  parameter int         DEB_CYCLES     = 50000,
  parameter logic [7:0] INIT_VAL       = 8'h00,
  parameter int         TIMEOUT_FRAMES = 600,
  parameter int         REPEAT_DELAY   = 30,
  parameter int         REPEAT_RATE    = 6
) (
  input  logic        clk,
  input  logic        rst,
  menu_ctrl_if.slave  bus
);
  localparam int   SEL_W  = $clog2(N_ITEMS);
  localparam int   CW     = $clog2(DEB_CYCLES + 1);
  localparam int   TW     = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic REP_OK = (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

  typedef enum logic {
    HIDDEN,
    SHOWN
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_MENU,
    EV_UP,
    EV_DOWN,
    EV_RIGHT,
    EV_LEFT
  } ev_t;

  // Button bit order doubles as priority order: menu is the MSB.
  logic [4:0]                raw;
  logic [4:0]                sync1_q, sync2_q;
  logic [4:0]                deb_q, deb_d;
  logic [4:0]                rise_q;
  logic [4:0][CW-1:0]        cnt_q, cnt_d;
  logic [3:0]                rep_ev;
  logic [4:0]                ev_all;

  ev_t                       pend_q, pend_d;
  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [N_ITEMS-1:0][7:0]   val_q, val_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic                      upd_q;

  assign raw = {bus.btn_menu, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left};

  function automatic ev_t prio(input logic [4:0] v);
    if (v[4]) return EV_MENU;
    if (v[3]) return EV_UP;
    if (v[2]) return EV_DOWN;
    if (v[1]) return EV_RIGHT;
    if (v[0]) return EV_LEFT;
    return EV_NONE;
  endfunction

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= deb_d & ~deb_q;
    end
  end

`ifdef MENU_AUTOREPEAT_EN
  logic [3:0]  hot;
  logic [3:0]  rep_btn_q, rep_btn_d;
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_run_q, rep_run_d;

  // Only the highest-priority held navigation button repeats; any change restarts the count.
  always_comb begin
    hot = 4'b0000;
    if (deb_q[3])      hot = 4'b1000;
    else if (deb_q[2]) hot = 4'b0100;
    else if (deb_q[1]) hot = 4'b0010;
    else if (deb_q[0]) hot = 4'b0001;
    rep_ev    = 4'b0000;
    rep_btn_d = rep_btn_q;
    rep_cnt_d = rep_cnt_q;
    rep_run_d = rep_run_q;
    if (state_q != SHOWN || hot == 4'b0000 || hot != rep_btn_q) begin
      rep_btn_d = (state_q == SHOWN) ? hot : 4'b0000;
      rep_cnt_d = '0;
      rep_run_d = 1'b0;
    end else if (bus.newframe) begin
      if ((!rep_run_q && rep_cnt_q == 16'(REPEAT_DELAY - 1)) ||
          ( rep_run_q && rep_cnt_q == 16'(REPEAT_RATE - 1))) begin
        rep_ev    = hot & {4{REP_OK}};
        rep_cnt_d = '0;
        rep_run_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_btn_q <= '0;
      rep_cnt_q <= '0;
      rep_run_q <= 1'b0;
    end else begin
      rep_btn_q <= rep_btn_d;
      rep_cnt_q <= rep_cnt_d;
      rep_run_q <= rep_run_d;
    end
  end
`else
  assign rep_ev = {4{REP_OK}} & 4'b0000;
`endif

  assign ev_all = rise_q | {1'b0, rep_ev};

  // The slot re-arms on newframe, so an event arriving with the strobe waits a full frame.
  always_comb begin
    pend_d = pend_q;
    if (bus.newframe || pend_q == EV_NONE) begin
      pend_d = prio(ev_all);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    val_d   = val_q;
    tcnt_d  = tcnt_q;
    if (bus.newframe) begin
      case (state_q)
        HIDDEN: begin
          if (pend_q == EV_MENU) begin
            state_d = SHOWN;
            sel_d   = '0;
            tcnt_d  = '0;
          end
        end
        SHOWN: begin
          if (pend_q != EV_NONE) begin
            tcnt_d = '0;
            case (pend_q)
              EV_MENU: begin
                state_d = HIDDEN;
                sel_d   = '0;
              end
              EV_UP:    sel_d = (sel_q == '0) ? SEL_W'(N_ITEMS - 1) : sel_q - SEL_W'(1);
              EV_DOWN:  sel_d = (sel_q == SEL_W'(N_ITEMS - 1)) ? '0 : sel_q + SEL_W'(1);
              EV_RIGHT: if (val_q[sel_q] != 8'hFF) val_d[sel_q] = val_q[sel_q] + 8'd1;
              EV_LEFT:  if (val_q[sel_q] != 8'h00) val_d[sel_q] = val_q[sel_q] - 8'd1;
              default: ;
            endcase
          end else if (TIMEOUT_FRAMES > 0) begin
            if (tcnt_q == TW'(TIMEOUT_FRAMES - 1)) begin
              state_d = HIDDEN;
              sel_d   = '0;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        default: state_d = HIDDEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= EV_NONE;
      state_q <= HIDDEN;
      sel_q   <= '0;
      val_q   <= {N_ITEMS{INIT_VAL}};
      tcnt_q  <= '0;
      upd_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      tcnt_q  <= tcnt_d;
      upd_q   <= bus.newframe;
    end
  end

  // Menu state only moves on newframe, so these registers already are the frame-stable view.
  assign bus.menu_on    = (state_q == SHOWN);
  assign bus.sel_item   = sel_q;
  assign bus.exit_value = val_q[sel_q];
  assign bus.cfg_values = val_q;
  assign bus.frame_upd  = upd_q;
endmodule

// File: tb/tb_menu_ctrl.sv
// tb/tb_menu_ctrl.sv - randomized frame-level bench for menu_ctrl against a rule-based model
module tb_menu_ctrl;
  localparam int NI = 4;
  localparam logic [4:0] B_MENU  = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  menu_ctrl_if #(.N_ITEMS(NI)) bus ();

  menu_ctrl #(
    .N_ITEMS(NI), .DEB_CYCLES(4), .INIT_VAL(8'h00), .TIMEOUT_FRAMES(3),
    .REPEAT_DELAY(30), .REPEAT_RATE(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.newframe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc = (cyc == 99) ? 0 : cyc + 1;
      bus.newframe = (cyc == 0);
    end
  end

  bit         m_on;
  int         m_sel;
  bit         m_sel_known;
  int         m_idle;
  logic [7:0] m_val [NI];

  task automatic model_reset();
    m_on = 0; m_sel = 0; m_sel_known = 1; m_idle = 0;
    for (int k = 0; k < NI; k++) m_val[k] = 8'h00;
  endtask

  function automatic logic [4:0] top_bit(input logic [4:0] v);
    for (int i = 4; i >= 0; i--) if (v[i]) return 5'(1 << i);
    return 5'b0;
  endfunction

  task automatic model_apply(input logic [4:0] ev);
    if (!m_on) begin
      if (ev == B_MENU) begin m_on = 1; m_sel = 0; m_sel_known = 1; m_idle = 0; end
    end else if (ev == 5'b0) begin
      m_idle++;
      if (m_idle == 3) begin m_on = 0; m_sel = 0; m_sel_known = 1; m_idle = 0; end
    end else begin
      m_idle = 0;
      case (ev)
        B_MENU:  begin m_on = 0; m_sel_known = 0; end
        B_UP:    m_sel = (m_sel + NI - 1) % NI;
        B_DOWN:  m_sel = (m_sel + 1) % NI;
        B_RIGHT: if (m_val[m_sel] < 8'hFF) m_val[m_sel] = m_val[m_sel] + 8'd1;
        B_LEFT:  if (m_val[m_sel] > 8'h00) m_val[m_sel] = m_val[m_sel] - 8'd1;
        default: ;
      endcase
    end
  endtask

  task automatic set_btns(input logic [4:0] v);
    {bus.btn_menu, bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left} = v;
  endtask

  // One frame: compare the just-updated display to the model, press a then b, compare again
  // mid-frame (nothing may move), then advance the model by the event that wins this frame.
  task automatic do_frame(input logic [4:0] a, input int len_a, input logic [4:0] b,
                          input string tag);
    int n;
    logic [4:0] a_eff;
    logic [8*NI-1:0] exp_cfg;
    n = 0;
    while (bus.newframe !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 300) begin n_fail++; $display("FAIL %s newframe wait expired", tag); end
    @(negedge clk);
    for (int k = 0; k < NI; k++) exp_cfg[8*k +: 8] = m_val[k];
    n_checks++;
    if (bus.frame_upd !== 1'b1) begin
      n_fail++; $display("FAIL %s frame_upd got %b want 1", tag, bus.frame_upd);
    end
    n_checks++;
    if (bus.menu_on !== m_on) begin
      n_fail++; $display("FAIL %s menu_on got %b want %b", tag, bus.menu_on, m_on);
    end
    n_checks++;
    if (bus.cfg_values !== exp_cfg) begin
      n_fail++; $display("FAIL %s cfg_values got %h want %h", tag, bus.cfg_values, exp_cfg);
    end
    if (m_sel_known) begin
      n_checks++;
      if (bus.sel_item !== 2'(m_sel)) begin
        n_fail++; $display("FAIL %s sel_item got %0d want %0d", tag, bus.sel_item, m_sel);
      end
      n_checks++;
      if (bus.exit_value !== m_val[m_sel]) begin
        n_fail++; $display("FAIL %s exit_value got %h want %h", tag, bus.exit_value, m_val[m_sel]);
      end
    end
    repeat (4) @(negedge clk);
    set_btns(a);
    repeat (len_a) @(negedge clk);
    set_btns(5'b0);
    repeat (20) @(negedge clk);
    set_btns(b);
    repeat (10) @(negedge clk);
    set_btns(5'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.frame_upd !== 1'b0 || bus.menu_on !== m_on || bus.cfg_values !== exp_cfg) begin
      n_fail++;
      $display("FAIL %s mid-frame change upd=%b on=%b cfg=%h want upd=0 on=%b cfg=%h",
               tag, bus.frame_upd, bus.menu_on, bus.cfg_values, m_on, exp_cfg);
    end
    a_eff = (len_a >= 4) ? a : 5'b0;
    model_apply((a_eff != 5'b0) ? top_bit(a_eff) : top_bit(b));
  endtask

  task automatic test_reset();
    set_btns(5'b0);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.menu_on !== 1'b0 || bus.sel_item !== 2'd0 || bus.exit_value !== 8'h00 ||
        bus.cfg_values !== 32'h0 || bus.frame_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state on=%b sel=%0d exit=%h cfg=%h upd=%b want all zero",
               bus.menu_on, bus.sel_item, bus.exit_value, bus.cfg_values, bus.frame_upd);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_show_glitch();
    do_frame(5'b0, 10, 5'b0, "idle_hidden");
    do_frame(B_MENU, 3, 5'b0, "menu_glitch");
    do_frame(5'b0, 10, 5'b0, "after_glitch");
    n_checks++;
    if (bus.menu_on !== 1'b0) begin n_fail++; $display("FAIL glitch_menu_on got %b want 0", bus.menu_on); end
    do_frame(B_MENU, 10, 5'b0, "menu_press");
    do_frame(5'b0, 10, 5'b0, "after_show");
    n_checks++;
    if (bus.menu_on !== 1'b1 || bus.sel_item !== 2'd0) begin
      n_fail++; $display("FAIL show on=%b sel=%0d want on=1 sel=0", bus.menu_on, bus.sel_item);
    end
  endtask

  task automatic test_navigation();
    do_frame(B_UP, 10, 5'b0, "nav_up");
    do_frame(B_DOWN, 10, 5'b0, "nav_down1");
    n_checks++;
    if (bus.sel_item !== 2'd3) begin n_fail++; $display("FAIL nav_wrap_up sel got %0d want 3", bus.sel_item); end
    do_frame(B_DOWN, 10, 5'b0, "nav_down2");
    n_checks++;
    if (bus.sel_item !== 2'd0) begin n_fail++; $display("FAIL nav_wrap_down sel got %0d want 0", bus.sel_item); end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 256; i++) begin
      do_frame(B_RIGHT, 10, 5'b0, "sat_right");
      if (i == 1) begin
        n_checks++;
        if (bus.sel_item !== 2'd1) begin n_fail++; $display("FAIL nav_sel1 got %0d want 1", bus.sel_item); end
      end
      if (i == 255) begin
        n_checks++;
        if (bus.exit_value !== 8'hFE) begin n_fail++; $display("FAIL sat_fe got %h want fe", bus.exit_value); end
      end
      if (i == 256) begin
        n_checks++;
        if (bus.exit_value !== 8'hFF) begin n_fail++; $display("FAIL sat_ff1 got %h want ff", bus.exit_value); end
      end
    end
    do_frame(B_DOWN, 10, 5'b0, "sat_move");
    n_checks++;
    if (bus.exit_value !== 8'hFF) begin n_fail++; $display("FAIL sat_ff2 got %h want ff", bus.exit_value); end
    do_frame(B_RIGHT, 10, 5'b0, "low_right");
    n_checks++;
    if (bus.sel_item !== 2'd2) begin n_fail++; $display("FAIL low_sel got %0d want 2", bus.sel_item); end
    do_frame(B_LEFT, 10, 5'b0, "low_left1");
    n_checks++;
    if (bus.exit_value !== 8'h01) begin n_fail++; $display("FAIL low_01 got %h want 01", bus.exit_value); end
    do_frame(B_LEFT, 10, 5'b0, "low_left2");
    n_checks++;
    if (bus.exit_value !== 8'h00) begin n_fail++; $display("FAIL low_00a got %h want 00", bus.exit_value); end
    do_frame(B_MENU | B_DOWN, 10, 5'b0, "low_hold");
    n_checks++;
    if (bus.exit_value !== 8'h00) begin n_fail++; $display("FAIL low_00b got %h want 00", bus.exit_value); end
    do_frame(B_MENU, 10, 5'b0, "reshow");
  endtask

  task automatic test_same_frame();
    do_frame(5'b0, 10, 5'b0, "pre_same");
    do_frame(B_DOWN, 10, 5'b0, "to_item1");
    do_frame(B_DOWN, 10, 5'b0, "to_item2");
    do_frame(B_RIGHT | B_LEFT, 10, B_RIGHT, "right_left");
    do_frame(5'b0, 10, 5'b0, "same_idle1");
    n_checks++;
    if (bus.exit_value !== 8'h01 || bus.sel_item !== 2'd2) begin
      n_fail++; $display("FAIL same_frame exit=%h sel=%0d want exit=01 sel=2", bus.exit_value, bus.sel_item);
    end
  endtask

  task automatic test_timeout();
    do_frame(5'b0, 10, 5'b0, "to_idle2");
    do_frame(5'b0, 10, 5'b0, "to_idle3");
    n_checks++;
    if (bus.menu_on !== 1'b1) begin n_fail++; $display("FAIL timeout_early got %b want 1", bus.menu_on); end
    do_frame(B_UP, 10, 5'b0, "hidden_up");
    n_checks++;
    if (bus.menu_on !== 1'b0 || bus.sel_item !== 2'd0 || bus.cfg_values !== 32'h0001FF00) begin
      n_fail++; $display("FAIL timeout_hide on=%b sel=%0d cfg=%h want on=0 sel=0 cfg=0001ff00",
                         bus.menu_on, bus.sel_item, bus.cfg_values);
    end
    do_frame(5'b0, 10, 5'b0, "hidden_idle");
    n_checks++;
    if (bus.menu_on !== 1'b0 || bus.sel_item !== 2'd0) begin
      n_fail++; $display("FAIL hidden_up on=%b sel=%0d want on=0 sel=0", bus.menu_on, bus.sel_item);
    end
  endtask

  task automatic test_random();
    logic [4:0] a, b;
    int r;
    do_frame(B_MENU, 10, 5'b0, "rnd_show");
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       a = 5'b0;
      else if (r == 2) a = B_MENU;
      else if (r < 9)  a = 5'(1 << $urandom_range(0, 3));
      else             a = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
      b = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'(1 << $urandom_range(0, 4));
      do_frame(a, ($urandom_range(0, 4) == 0) ? 3 : 10, b, "random");
    end
  endtask

  task automatic test_async_reset();
    do_frame(B_RIGHT, 10, 5'b0, "pre_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.menu_on !== 1'b0 || bus.sel_item !== 2'd0 || bus.exit_value !== 8'h00 ||
        bus.cfg_values !== 32'h0 || bus.frame_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset on=%b sel=%0d exit=%h cfg=%h upd=%b want all zero",
               bus.menu_on, bus.sel_item, bus.exit_value, bus.cfg_values, bus.frame_upd);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_frame(5'b0, 10, 5'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_show_glitch();
    test_navigation();
    test_saturation();
    test_same_frame();
    test_timeout();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
